id_stage: RTL and testbench

Instruction-decode stage that consumes the IF/ID pipeline outputs (pc, instruction) and produces the registered ID/EX pipeline bundle. The bundle carries register operands, the extended immediate, the destination register and the control signals.
- Holds the 32x32 architectural register file; the writeback port updates it.
- Detects load-use hazards against the instruction currently in its own output register and inserts a bubble.

---
 rtl/id_stage.sv | 223 ++++++++++++++++++++++
 tb/tb_id_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Instruction-decode stage: register file, field decode, load-use hazard
// detection and the registered ID/EX bundle. Define REGFILE_BYPASS_EN for write-through reads.
module id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] instruction_in,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        hazard_stall,
  output logic [31:0] pc_out,
  output logic [31:0] rs_data_out,
  output logic [31:0] rt_data_out,
  output logic [31:0] imm_out,
  output logic [4:0]  shamt_out,
  output logic [4:0]  rs_out,
  output logic [4:0]  rt_out,
  output logic [4:0]  dest_out,
  output logic [3:0]  alu_op_out,
  output logic        reg_write_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic        mem_to_reg_out,
  output logic        alu_src_out,
  output logic        branch_out,
  output logic        branch_ne_out,
  output logic        jump_out,
  output logic        jump_reg_out,
  output logic        link_out,
  output logic        illegal_out
);

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
    ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7,
    ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11
  } alu_op_e;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03, OP_BEQ  = 6'h04,
    OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
    OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI   = 6'h0D, OP_XORI = 6'h0E,
    OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW    = 6'h2B
  } opcode_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [3:0]  alu_op;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic        branch;
    logic        branch_ne;
    logic        jump;
    logic        jump_reg;
    logic        link;
    logic        illegal;
  } idex_t;

  // pc is the most-significant field, so the bubble is RESET_PC over zeros
  localparam idex_t BUBBLE = idex_t'({RESET_PC, {($bits(idex_t) - 32){1'b0}}});

  logic [31:0] regs [NUM_REGS];
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [31:0] imm_sext, imm_zext;
  logic [31:0] rs_data, rt_data;
  idex_t       dec;
  idex_t       q;

  assign op       = instruction_in[31:26];
  assign rs       = instruction_in[25:21];
  assign rt       = instruction_in[20:16];
  assign rd       = instruction_in[15:11];
  assign funct    = instruction_in[5:0];
  assign imm_sext = {{16{instruction_in[15]}}, instruction_in[15:0]};
  assign imm_zext = {16'h0000, instruction_in[15:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (wb_en && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rs_data = (rs == '0) ? '0 : regs[rs];
    rt_data = (rt == '0) ? '0 : regs[rt];
`ifdef REGFILE_BYPASS_EN
    if (wb_en && (wb_addr != '0) && (wb_addr == rs)) rs_data = wb_data;
    if (wb_en && (wb_addr != '0) && (wb_addr == rt)) rt_data = wb_data;
`endif
  end

  always_comb begin
    dec         = '0;
    dec.pc      = pc_in;
    dec.rs_data = rs_data;
    dec.rt_data = rt_data;
    dec.imm     = imm_sext;
    dec.shamt   = instruction_in[10:6];
    dec.rs      = rs;
    dec.rt      = rt;
    dec.alu_op  = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        dec.reg_write = 1'b1;
        dec.dest      = rd;
        case (funct)
          6'h20, 6'h21: dec.alu_op = ALU_ADD;
          6'h22, 6'h23: dec.alu_op = ALU_SUB;
          6'h24: dec.alu_op = ALU_AND;
          6'h25: dec.alu_op = ALU_OR;
          6'h26: dec.alu_op = ALU_XOR;
          6'h27: dec.alu_op = ALU_NOR;
          6'h2A: dec.alu_op = ALU_SLT;
          6'h2B: dec.alu_op = ALU_SLTU;
          6'h00: dec.alu_op = ALU_SLL;
          6'h02: dec.alu_op = ALU_SRL;
          6'h03: dec.alu_op = ALU_SRA;
          6'h08: begin
            dec.reg_write = 1'b0;
            dec.dest      = '0;
            dec.jump_reg  = 1'b1;
          end
          default: begin
            dec.reg_write = 1'b0;
            dec.dest      = '0;
            dec.illegal   = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_LUI, OP_LW: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.dest      = rt;
        case (op)
          OP_ANDI:  begin dec.alu_op = ALU_AND;  dec.imm = imm_zext; end
          OP_ORI:   begin dec.alu_op = ALU_OR;   dec.imm = imm_zext; end
          OP_XORI:  begin dec.alu_op = ALU_XOR;  dec.imm = imm_zext; end
          OP_SLTI:  dec.alu_op = ALU_SLT;
          OP_SLTIU: dec.alu_op = ALU_SLTU;
          OP_LUI:   begin dec.alu_op = ALU_LUI;  dec.imm = {instruction_in[15:0], 16'h0000}; end
          OP_LW:    begin dec.mem_read = 1'b1;   dec.mem_to_reg = 1'b1; end
          default:  dec.alu_op = ALU_ADD;
        endcase
      end
      OP_SW: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OP_BEQ: begin
        dec.branch = 1'b1;
        dec.alu_op = ALU_SUB;
      end
      OP_BNE: begin
        dec.branch    = 1'b1;
        dec.branch_ne = 1'b1;
        dec.alu_op    = ALU_SUB;
      end
      OP_J, OP_JAL: begin
        dec.jump = 1'b1;
        dec.imm  = {pc_in[31:28], instruction_in[25:0], 2'b00};
        if (op == OP_JAL) begin
          dec.link      = 1'b1;
          dec.reg_write = 1'b1;
          dec.dest      = 5'd31;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign hazard_stall = q.mem_read && (q.dest != '0) &&
                        ((q.dest == rs) || (q.dest == rt)) && !stall && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               q <= BUBBLE;
    else if (flush)        q <= BUBBLE;
    else if (stall)        q <= q;
    else if (hazard_stall) q <= BUBBLE;
    else                   q <= dec;
  end

  assign pc_out         = q.pc;
  assign rs_data_out    = q.rs_data;
  assign rt_data_out    = q.rt_data;
  assign imm_out        = q.imm;
  assign shamt_out      = q.shamt;
  assign rs_out         = q.rs;
  assign rt_out         = q.rt;
  assign dest_out       = q.dest;
  assign alu_op_out     = q.alu_op;
  assign reg_write_out  = q.reg_write;
  assign mem_read_out   = q.mem_read;
  assign mem_write_out  = q.mem_write;
  assign mem_to_reg_out = q.mem_to_reg;
  assign alu_src_out    = q.alu_src;
  assign branch_out     = q.branch;
  assign branch_ne_out  = q.branch_ne;
  assign jump_out       = q.jump;
  assign jump_reg_out   = q.jump_reg;
  assign link_out       = q.link;
  assign illegal_out    = q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage; expected values are hand-decoded.
module tb_id_stage;

  logic        clk, rst, stall, flush;
  logic [31:0] pc_in, instruction_in;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        hazard_stall;
  logic [31:0] pc_out, rs_data_out, rt_data_out, imm_out;
  logic [4:0]  shamt_out, rs_out, rt_out, dest_out;
  logic [3:0]  alu_op_out;
  logic        reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out, alu_src_out;
  logic        branch_out, branch_ne_out, jump_out, jump_reg_out, link_out, illegal_out;

  int total = 0;
  int bad   = 0;

  id_stage #(.RESET_PC(32'h0000_0000), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .pc_in(pc_in), .instruction_in(instruction_in),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .hazard_stall(hazard_stall), .pc_out(pc_out),
    .rs_data_out(rs_data_out), .rt_data_out(rt_data_out), .imm_out(imm_out),
    .shamt_out(shamt_out), .rs_out(rs_out), .rt_out(rt_out), .dest_out(dest_out),
    .alu_op_out(alu_op_out), .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .mem_to_reg_out(mem_to_reg_out), .alu_src_out(alu_src_out),
    .branch_out(branch_out), .branch_ne_out(branch_ne_out), .jump_out(jump_out),
    .jump_reg_out(jump_reg_out), .link_out(link_out), .illegal_out(illegal_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    pc_in = 32'h0; instruction_in = 32'h0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    tick(); tick();
    check("rst_pc", pc_out, 32'h0);
    check("rst_regwrite", reg_write_out, 0);
    check("rst_dest", dest_out, 0);
    check("rst_imm", imm_out, 0);
    check("rst_hazard", hazard_stall, 0);
    rst = 1'b0;

    // addi $1,$0,-5
    pc_in = 32'h100; instruction_in = 32'h2001FFFB;
    tick();
    check("addi_aluop", alu_op_out, 0);
    check("addi_alusrc", alu_src_out, 1);
    check("addi_regwrite", reg_write_out, 1);
    check("addi_dest", dest_out, 1);
    check("addi_imm", imm_out, 32'hFFFFFFFB);
    check("addi_pc", pc_out, 32'h100);
    check("addi_rt", rt_out, 1);

    // write $3, then add $4,$3,$0
    instruction_in = 32'h0; wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF;
    tick();
    wb_en = 1'b0; pc_in = 32'h104; instruction_in = 32'h00602020;
    tick();
    check("add_rsdata", rs_data_out, 32'hDEADBEEF);
    check("add_dest", dest_out, 4);
    check("add_alusrc", alu_src_out, 0);

    // write to $0 must be ignored; add $4,$0,$3
    instruction_in = 32'h0; wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    tick();
    wb_en = 1'b0; instruction_in = 32'h00032020;
    tick();
    check("r0_rsdata", rs_data_out, 0);
    check("r0_rtdata", rt_data_out, 32'hDEADBEEF);

    // $5 = 0xAAAA, then same-cycle write 0x1234 while decoding or $6,$5,$0
    instruction_in = 32'h0; wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000AAAA;
    tick();
    wb_data = 32'h00001234; instruction_in = 32'h00A03025;
    tick();
`ifdef REGFILE_BYPASS_EN
    check("bypass_rsdata", rs_data_out, 32'h00001234);
`else
    check("nobypass_rsdata", rs_data_out, 32'h0000AAAA);
`endif
    check("or_aluop", alu_op_out, 3);
    check("or_dest", dest_out, 6);
    wb_en = 1'b0;
    tick();
    check("or_after_wb", rs_data_out, 32'h00001234);

    // load-use: lw $2,0($1) then add $3,$2,$2
    pc_in = 32'h200; instruction_in = 32'h8C220000;
    tick();
    check("lw_memread", mem_read_out, 1);
    check("lw_memtoreg", mem_to_reg_out, 1);
    check("lw_dest", dest_out, 2);
    pc_in = 32'h204; instruction_in = 32'h00421820;
    #1;
    check("lu_hazard", hazard_stall, 1);
    tick();
    check("lu_bubble_rw", reg_write_out, 0);
    check("lu_bubble_dest", dest_out, 0);
    check("lu_bubble_pc", pc_out, 0);
    check("lu_bubble_mr", mem_read_out, 0);
    check("lu_hazard_clear", hazard_stall, 0);
    tick();
    check("lu_add_dest", dest_out, 3);
    check("lu_add_rw", reg_write_out, 1);
    check("lu_add_pc", pc_out, 32'h204);

    // stall holds for 3 cycles despite changing inputs
    stall = 1'b1;
    pc_in = 32'h300; instruction_in = 32'h3C071234;
    tick();
    check("stall1_dest", dest_out, 3);
    pc_in = 32'h304; instruction_in = 32'hFC000000;
    tick();
    check("stall2_pc", pc_out, 32'h204);
    pc_in = 32'h308; instruction_in = 32'h30088001;
    tick();
    check("stall3_dest", dest_out, 3);
    check("stall3_aluop", alu_op_out, 0);
    flush = 1'b1;
    tick();
    check("flush_pc", pc_out, 0);
    check("flush_dest", dest_out, 0);
    check("flush_rw", reg_write_out, 0);
    flush = 1'b0; stall = 1'b0;

    // stall and flush suppress the hazard request
    pc_in = 32'h400; instruction_in = 32'h8C220000;
    tick();
    instruction_in = 32'h00421820; stall = 1'b1;
    #1;
    check("hz_stall_masked", hazard_stall, 0);
    stall = 1'b0;
    #1;
    check("hz_active", hazard_stall, 1);
    flush = 1'b1;
    #1;
    check("hz_flush_masked", hazard_stall, 0);
    tick();
    check("hz_flush_bubble", mem_read_out, 0);
    flush = 1'b0;

    // jal at 0x40000000
    pc_in = 32'h40000000; instruction_in = 32'h0C000010;
    tick();
    check("jal_jump", jump_out, 1);
    check("jal_link", link_out, 1);
    check("jal_dest", dest_out, 31);
    check("jal_rw", reg_write_out, 1);
    check("jal_imm", imm_out, 32'h40000040);

    // undefined opcode 0x3F
    instruction_in = 32'hFC000000;
    tick();
    check("ill_flag", illegal_out, 1);
    check("ill_rw", reg_write_out, 0);
    check("ill_dest", dest_out, 0);

    // lui $7,0x1234
    instruction_in = 32'h3C071234;
    tick();
    check("lui_imm", imm_out, 32'h12340000);
    check("lui_aluop", alu_op_out, 11);
    check("lui_ill", illegal_out, 0);

    // andi $8,$0,0x8001 zero-extends
    instruction_in = 32'h30088001;
    tick();
    check("andi_imm", imm_out, 32'h00008001);
    check("andi_aluop", alu_op_out, 2);

    // sra $9,$0,3
    instruction_in = 32'h000048C3;
    tick();
    check("sra_aluop", alu_op_out, 10);
    check("sra_shamt", shamt_out, 3);
    check("sra_dest", dest_out, 9);

    // bne $1,$2,-1
    instruction_in = 32'h1422FFFF;
    tick();
    check("bne_branch", branch_out, 1);
    check("bne_ne", branch_ne_out, 1);
    check("bne_aluop", alu_op_out, 1);
    check("bne_imm", imm_out, 32'hFFFFFFFF);
    check("bne_rw", reg_write_out, 0);

    // sw $2,4($1)
    instruction_in = 32'hAC220004;
    tick();
    check("sw_memwrite", mem_write_out, 1);
    check("sw_rw", reg_write_out, 0);
    check("sw_alusrc", alu_src_out, 1);

    // jr $31
    instruction_in = 32'h03E00008;
    tick();
    check("jr_jumpreg", jump_reg_out, 1);
    check("jr_rw", reg_write_out, 0);

    // unknown funct
    instruction_in = 32'h00000001;
    tick();
    check("badfunct_ill", illegal_out, 1);
    check("badfunct_rw", reg_write_out, 0);

    // reset during a write discards it and clears the file
    wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'h00000055; rst = 1'b1;
    #1;
    check("arst_pc", pc_out, 0);
    check("arst_ill", illegal_out, 0);
    tick();
    rst = 1'b0; wb_en = 1'b0;
    pc_in = 32'h500; instruction_in = 32'h006A5820;
    tick();
    check("postrst_r3", rs_data_out, 0);
    check("postrst_r10", rt_data_out, 0);
    check("postrst_dest", dest_out, 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
